// File: rtl/seq_divider_32bits.sv
// Iterative unsigned radix-2 restoring divider with start/done handshake.
// One trial subtraction per clock; WIDTH iterations per division.
module seq_divider_32bits #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;

  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   d_q;
  logic [WIDTH-1:0]   r_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;
  logic               div_zero_q;

  logic               start_ok;
  logic               div_by_zero;
  logic               last_iter;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   r_step;
  logic [WIDTH-1:0]   q_step;

  // Start is only honoured outside CALC; zero divisor bypasses the iteration.
  assign start_ok    = start_in && (state_q != S_CALC);
  assign div_by_zero = (divisor_in == '0);
  assign last_iter   = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, try subtracting the divisor.
  always_comb begin
    r_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    trial   = {1'b0, r_shift} - {1'b0, d_q};
    r_step  = r_shift;
    q_step  = {q_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_step = trial[WIDTH-1:0];
      q_step = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d = div_by_zero ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_CALC) begin
      busy_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
  end

  // Working registers: load on accepted start, iterate while in CALC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      q_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (start_ok) begin
      q_q   <= dividend_in;
      d_q   <= divisor_in;
      r_q   <= '0;
      cnt_q <= '0;
    end else if (state_q == S_CALC) begin
      q_q   <= q_step;
      r_q   <= r_step;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs; results change together only on entry to DONE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (start_ok && div_by_zero) begin
        quotient_q  <= '1;
        remainder_q <= dividend_in;
        div_zero_q  <= 1'b1;
      end else if (last_iter) begin
        quotient_q  <= q_step;
        remainder_q <= r_step;
        div_zero_q  <= 1'b0;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_divider_32bits.sv
// Self-checking bench for seq_divider_32bits: vector table, corner sequences,
// random pairs; results checked through an expected-value queue.
module tb_seq_divider_32bits;

  localparam int unsigned W = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic [W-1:0]  dividend_in;
  logic [W-1:0]  divisor_in;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  quotient_o;
  logic [W-1:0]  remainder_o;
  logic          div_zero_o;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  int errors = 0;
  int checks = 0;

  seq_divider_32bits #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .start_in    (start_in),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending result at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("quotient", 64'(quotient_o), 64'(e.q));
        chk("remainder", 64'(remainder_o), 64'(e.r));
        chk("div_zero", 64'(div_zero_o), 64'(e.dz));
      end
    end
  end

  // Waits (bounded) for done_o, counting negedges since the start edge and busy cycles.
  task automatic wait_done(output int cycles, output int busy_n);
    cycles = 1;
    busy_n = 0;
    while (!done_o && cycles < 100) begin
      if (busy_o) busy_n++;
      @(negedge clk_in);
      cycles++;
    end
  endtask

  // Called at a negedge: issues one start, pushes the expectation, checks timing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int   cycles;
    int   busy_n;
    exp_t e;
    dividend_in = a;
    divisor_in  = b;
    start_in    = 1'b1;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    sb.push_back(e);
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(cycles, busy_n);
    chk("latency", 64'(cycles), (b == '0) ? 64'd1 : 64'd33);
    chk("busy_cycles", 64'(busy_n), (b == '0) ? 64'd0 : 64'd32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cycles;
    int            busy_n;
    int            dn;
    int            mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tbl[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    tbl[3] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
    tbl[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[5] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0};
    tbl[6] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    tbl[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    tbl[8] = '{32'h1234_5678,  32'hFFFF_FFFF,  32'd0,          32'h1234_5678,  1'b0};
    tbl[9] = '{32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF,  1'b0};

    rst_n_in    = 1'b0;
    start_in    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_quotient", 64'(quotient_o), 64'd0);
    chk("reset_remainder", 64'(remainder_o), 64'd0);
    chk("reset_div_zero", 64'(div_zero_o), 64'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Vector table, each op separated by an idle cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
      @(negedge clk_in);
      chk("done_pulse_width", 64'(done_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
    end

    // Start during CALC is ignored.
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start_in    = 1'b1;
    sb.push_back('{32'd14, 32'd2, 1'b0});
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    dividend_in = 32'd9;
    divisor_in  = 32'd2;
    start_in    = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(cycles, busy_n);
    chk("ignored_start_latency", 64'(cycles + 4), 64'd33);
    @(negedge clk_in);
    chk("ignored_start_no_restart", 64'(busy_o), 64'd0);

    // Reset in CALC cycle 10 aborts without a done pulse.
    dividend_in = 32'd100;
    divisor_in  = 32'd7;
    start_in    = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (9) @(negedge clk_in);
    chk("busy_before_abort", 64'(busy_o), 64'd1);
    rst_n_in = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_quotient", 64'(quotient_o), 64'd0);
    chk("abort_remainder", 64'(remainder_o), 64'd0);
    chk("abort_div_zero", 64'(div_zero_o), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (done_o || busy_o) dn++;
    end
    chk("no_activity_after_abort", 64'(dn), 64'd0);
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(negedge clk_in);

    // Back-to-back: second start issued in the done cycle.
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    chk("b2b_done_high", 64'(done_o), 64'd1);
    run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    @(negedge clk_in);

    // Random pairs issued back-to-back, reference from the language operators.
    for (int i = 0; i < 200; i++) begin
      mode = int'($urandom_range(0, 4));
      a = $urandom();
      case (mode)
        0: b = 32'd1;
        1: b = 32'hFFFF_FFFF;
        2: begin
          a = a >> 1;
          b = a + 32'($urandom_range(1, 1000));
        end
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      if (b == '0) begin
        run_op(a, b, 32'hFFFF_FFFF, a, 1'b1);
      end else begin
        run_op(a, b, a / b, a % b, 1'b0);
      end
    end
    repeat (2) @(negedge clk_in);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
